// File: rtl/conv_encoder_tx.sv
// rtl/conv_encoder_tx.sv - rate-1/2 K=3 convolutional encoder (G1=7, G2=5) with BPSK Q3.4 mapper
module conv_encoder_tx #(
  parameter int                 FRAME_LEN = 16,
  parameter logic signed [7:0]  AMP       = 8'sh10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic signed [7:0] r1,
  output logic signed [7:0] r2,
  output logic [1:0]        c_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  localparam logic [7:0]        LP_LEN = 8'(FRAME_LEN);
  localparam logic signed [7:0] LP_POS = AMP;
  localparam logic signed [7:0] LP_NEG = -AMP;

  logic [1:0]        r_state;
  logic [1:0]        r_s;
  logic [7:0]        r_cnt;
  logic              r_tail;
  logic signed [7:0] r_r1;
  logic signed [7:0] r_r2;
  logic [1:0]        r_c;
  logic              r_out_valid;
  logic              r_out_last;

  logic w_free;
  logic w_accept;
  logic w_tail_step;
  logic w_load;
  logic w_b;
  logic w_c1;
  logic w_c2;

  // Output register can take a new pair when empty or being drained this cycle
  assign w_free      = !r_out_valid || out_ready;
  assign in_ready    = ((r_state == ST_IDLE) || (r_state == ST_DATA)) && w_free;
  assign w_accept    = in_valid && in_ready;
  assign w_tail_step = (r_state == ST_TAIL) && w_free;
  assign w_load      = w_accept || w_tail_step;

  // Tail bits are forced to zero so the trellis terminates in state 00
  assign w_b  = (r_state == ST_TAIL) ? 1'b0 : in_bit;
  assign w_c1 = w_b ^ r_s[1] ^ r_s[0];
  assign w_c2 = w_b ^ r_s[0];

  // Frame sequencing: information bits, then two tail bits, then back to idle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_s     <= 2'b00;
      r_cnt   <= 8'd0;
      r_tail  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_s     <= {in_bit, r_s[1]};
            r_cnt   <= 8'd1;
            r_tail  <= 1'b0;
            r_state <= (LP_LEN == 8'd1) ? ST_TAIL : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_s   <= {in_bit, r_s[1]};
            r_cnt <= r_cnt + 8'd1;
            if ((r_cnt + 8'd1) == LP_LEN) begin
              r_state <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          if (w_free) begin
            if (r_tail) begin
              r_s     <= 2'b00;
              r_tail  <= 1'b0;
              r_cnt   <= 8'd0;
              r_state <= ST_IDLE;
            end else begin
              r_s    <= {1'b0, r_s[1]};
              r_tail <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_s     <= 2'b00;
          r_cnt   <= 8'd0;
          r_tail  <= 1'b0;
        end
      endcase
    end
  end

  // Single-stage output register; data holds when drained without a reload
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_r1        <= 8'sd0;
      r_r2        <= 8'sd0;
      r_c         <= 2'b00;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_tail_step && r_tail;
      r_r1        <= w_c1 ? LP_NEG : LP_POS;
      r_r2        <= w_c2 ? LP_NEG : LP_POS;
      r_c         <= {w_c1, w_c2};
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign r1        = r_r1;
  assign r2        = r_r2;
  assign c_bits    = r_c;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb/tb_conv_encoder_tx.sv - self-checking bench for conv_encoder_tx with a polynomial reference model
module tb_conv_encoder_tx;

  localparam int FL = 4;

  typedef struct packed {
    logic [1:0] c;
    logic [7:0] r1;
    logic [7:0] r2;
    logic       last;
  } beat_t;

  logic              CLK;
  logic              RST_N;
  logic              in_bit;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] r1;
  logic signed [7:0] r2;
  logic [1:0]        c_bits;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  int total;
  int bad;

  logic  in_q[$];
  beat_t obs_q[$];
  beat_t exp_q[$];
  logic  busy_q[$];
  int    stab_viol;
  int    rdy_viol;
  int    blocked;

  conv_encoder_tx #(.FRAME_LEN(FL), .AMP(8'sh10)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .c_bits(c_bits), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: code bits as the convolution of the zero-terminated frame with 1+D+D^2 and 1+D^2
  task automatic model_frame(input logic u[FL]);
    for (int k = 0; k < FL + 2; k++) begin
      logic u0, u1, u2, c1, c2;
      beat_t b;
      u0 = (k < FL) ? u[k] : 1'b0;
      u1 = (k >= 1 && k - 1 < FL) ? u[k-1] : 1'b0;
      u2 = (k >= 2 && k - 2 < FL) ? u[k-2] : 1'b0;
      c1 = u0 ^ u1 ^ u2;
      c2 = u0 ^ u2;
      b.c    = {c1, c2};
      b.r1   = c1 ? 8'(-16) : 8'(16);
      b.r2   = c2 ? 8'(-16) : 8'(16);
      b.last = (k == FL + 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_all();
    in_q.delete(); obs_q.delete(); exp_q.delete(); busy_q.delete();
    stab_viol = 0; rdy_viol = 0; blocked = 0;
  endtask

  // Cycle driver: mode 0 ready high, mode 1 ready 1,0,0,1 pattern, mode 2 random ready
  task automatic run(input int mode, input int target, output int to_flag);
    int    cyc;
    beat_t prev;
    logic  prev_stall;
    cyc = 0; prev_stall = 1'b0; prev = '0; to_flag = 0;
    while (obs_q.size() < target) begin
      if (cyc >= 400) begin
        to_flag = 1;
        break;
      end
      @(negedge CLK);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (in_q.size() > 0);
      in_bit   = in_valid ? in_q[0] : 1'b0;
      #1;
      if (prev_stall && (out_valid !== 1'b1 || {c_bits, r1, r2, out_last} !== prev)) stab_viol++;
      if (out_valid && !out_ready && in_ready) rdy_viol++;
      if (in_valid && !in_ready && out_ready) blocked++;
      busy_q.push_back(busy);
      if (in_valid && in_ready) void'(in_q.pop_front());
      if (out_valid && out_ready) obs_q.push_back({c_bits, r1, r2, out_last});
      prev_stall = out_valid && !out_ready;
      prev = {c_bits, r1, r2, out_last};
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int to;
    clear_all();
    in_q.push_back(1'b1); in_q.push_back(1'b1);
    run(0, 1, to);
    total++;
    if (to != 0 || out_valid !== 1'b1 || r1 !== 8'hF0) begin
      bad++; $display("FAIL reset_pre: to=%0d out_valid=%b r1=%h want 0/1/f0", to, out_valid, r1);
    end
    #2 RST_N = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL reset_valid: out_valid=%b out_last=%b want 0 0", out_valid, out_last);
    end
    total++;
    if (r1 !== 8'h00 || r2 !== 8'h00 || c_bits !== 2'b00) begin
      bad++; $display("FAIL reset_data: r1=%h r2=%h c=%b want 00 00 00", r1, r2, c_bits);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy: busy=%b want 0", busy);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic check_beats(input string name, input int to);
    total++;
    if (to != 0 || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s_count: got %0d beats want %0d (timeout=%0d)", name, obs_q.size(), exp_q.size(), to);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL %s_beat%0d: got %h want %h", name, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_basic();
    int   to;
    logic u[FL];
    logic [11:0] seq;
    clear_all();
    u = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < FL; i++) in_q.push_back(u[i]);
    model_frame(u);
    run(0, FL + 2, to);
    check_beats("basic", to);
    seq = 12'b11_10_00_01_01_11;
    if (obs_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (obs_q[i].c !== seq[11-2*i -: 2] || obs_q[i].last !== (i == 5)) begin
          bad++; $display("FAIL basic_table%0d: c=%b last=%b want c=%b last=%b", i, obs_q[i].c, obs_q[i].last, seq[11-2*i -: 2], (i == 5));
        end
      end
    end
  endtask

  task automatic test_stall();
    int   to;
    logic u[FL];
    clear_all();
    u = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < FL; i++) in_q.push_back(u[i]);
    model_frame(u);
    run(1, FL + 2, to);
    check_beats("stall", to);
    total++;
    if (stab_viol != 0 || rdy_viol != 0) begin
      bad++; $display("FAIL stall_hold: stab_viol=%0d rdy_viol=%0d want 0 0", stab_viol, rdy_viol);
    end
  endtask

  task automatic test_back_to_back();
    int   to, first_hi, lows;
    logic u[FL], v[FL];
    clear_all();
    u = '{1'b1, 1'b0, 1'b1, 1'b1};
    v = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < FL; i++) in_q.push_back(u[i]);
    for (int i = 0; i < FL; i++) in_q.push_back(v[i]);
    model_frame(u);
    model_frame(v);
    run(0, 2 * (FL + 2), to);
    check_beats("b2b", to);
    first_hi = -1; lows = 0;
    for (int i = 0; i < busy_q.size(); i++) begin
      if (first_hi < 0) begin
        if (busy_q[i]) first_hi = i;
      end else if (!busy_q[i]) begin
        lows++;
      end else if (lows > 0) begin
        break;
      end
    end
    total++;
    if (lows != 1) begin
      bad++; $display("FAIL b2b_busy_gap: low cycles=%0d want 1", lows);
    end
    total++;
    if (blocked != 2) begin
      bad++; $display("FAIL b2b_tail_block: blocked=%0d want 2", blocked);
    end
  endtask

  task automatic test_tail_valid();
    int   to;
    logic u[FL], v[FL];
    clear_all();
    u = '{1'b0, 1'b1, 1'b1, 1'b0};
    v = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < FL; i++) in_q.push_back(u[i]);
    for (int i = 0; i < FL; i++) in_q.push_back(v[i]);
    model_frame(u);
    model_frame(v);
    run(0, 2 * (FL + 2), to);
    check_beats("tailv", to);
    total++;
    if (blocked != 2) begin
      bad++; $display("FAIL tailv_block: blocked=%0d want 2", blocked);
    end
  endtask

  task automatic test_random();
    int   to;
    logic u[FL];
    clear_all();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FL; i++) begin
        u[i] = 1'($urandom_range(0, 1));
        in_q.push_back(u[i]);
      end
      model_frame(u);
    end
    run(2, 3 * (FL + 2), to);
    check_beats("rand", to);
    total++;
    if (stab_viol != 0 || rdy_viol != 0) begin
      bad++; $display("FAIL rand_hold: stab_viol=%0d rdy_viol=%0d want 0 0", stab_viol, rdy_viol);
    end
  endtask

  task automatic test_reset_midframe();
    int   to, lasts;
    logic u[FL];
    clear_all();
    in_q.push_back(1'b1); in_q.push_back(1'b0);
    run(0, 2, to);
    lasts = 0;
    foreach (obs_q[i]) if (obs_q[i].last) lasts++;
    total++;
    if (to != 0 || obs_q.size() != 2 || lasts != 0) begin
      bad++; $display("FAIL midrst_pre: beats=%0d lasts=%0d to=%0d want 2 0 0", obs_q.size(), lasts, to);
    end
    #2 RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    clear_all();
    u = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < FL; i++) in_q.push_back(u[i]);
    model_frame(u);
    run(0, FL + 2, to);
    check_beats("midrst", to);
  endtask

  initial begin
    total = 0; bad = 0;
    RST_N = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_tail_valid();
    test_random();
    test_reset_midframe();
    repeat (4) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
